reg_dump_ctrl: RTL and testbench
================================

# reg_dump_ctrl

Sequencer that reads the whole register file out through read port 1 on request (halt or debug) and streams each word over a valid/ready handshake. It sits between the datapath and the register file interface. When idle it is a transparent pass-through for the datapath's select and write signals. While dumping it owns read port 1, blocks writes, raises `busy` to stall the datapath, and keeps a running checksum of the words it has emitted.

## Interface
Parameters:
- `NREGS`, 32, number of registers to read (power of two, at most 2^AW).
- `AW`, 5, register index width.
- `DW`, 32, data width.
- `SKIP_ZERO`, 1, when 1 the dump starts at index 1; when 0 it starts at index 0.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: clock; all state updates on the rising edge.
- `n_rst` input 1: asynchronous active-low reset.
- `dump_start` input 1: request a dump; level-sampled, acted on only in IDLE.
- `dp_WEN` input 1: datapath write enable.
- `dp_wsel` input AW: datapath write select.
- `dp_wdat` input DW: datapath write data.
- `dp_rsel1` input AW: datapath read select, port 1.
- `dp_rsel2` input AW: datapath read select, port 2.
- `rf_WEN` output 1: write enable to the register file.
- `rf_wsel` output AW: write select to the register file.
- `rf_wdat` output DW: write data to the register file.
- `rf_rsel1` output AW: read select, port 1.
- `rf_rsel2` output AW: read select, port 2.
- `rf_rdat1` input DW: read data from port 1 (combinational from `rf_rsel1`).
- `out_valid` output 1: stream word valid.
- `out_ready` input 1: consumer accepts the word.
- `out_data` output DW: register value.
- `out_idx` output AW: index of `out_data`.
- `busy` output 1: dump in progress; datapath must stall.
- `dump_done` output 1: one-cycle pulse at the end of a dump.
- `checksum` output DW: running sum of the words emitted in the current or last dump.

## Operation
- States: IDLE, DRAIN, READ, DONE.
- IDLE:
  - All `rf_*` outputs equal the corresponding `dp_*` inputs.
  - `out_valid`=0 and `busy`=0.
  - When `dump_start`=1: go to DRAIN, clear `checksum`, load `idx` with `SKIP_ZERO ? 1 : 0`.
- DRAIN: exactly one cycle. Gives a write issued in the last pass-through cycle time to land (the register file writes on the falling edge), then goes to READ.
- READ:
  - `rf_rsel1`=`idx`, `out_data`=`rf_rdat1`, `out_idx`=`idx`, `out_valid`=1.
  - On a rising edge with `out_ready`=1: `checksum` += `out_data` (mod 2^DW).
  - If `idx`==NREGS-1, go to DONE; otherwise `idx`++.
  - While `out_ready`=0, `idx` and `out_data` hold stable.
- DONE: `dump_done`=1 for one cycle, then IDLE. `checksum` holds its value until the next dump starts.
- In DRAIN, READ and DONE:
  - `rf_WEN`=0, `busy`=1.
  - `rf_rsel2`, `rf_wsel` and `rf_wdat` pass through from the datapath, ignored by the register file since `rf_WEN`=0.
  - `rf_rsel1` comes from `idx` (READ only).
- `dump_start` is ignored outside IDLE. If it is still high in the cycle after DONE, a new dump starts.
- A `dp_WEN` that arrives during a dump is dropped, not queued. Stalling the datapath on `busy` is the datapath's responsibility.

## Timing
- Reset (asynchronous, any state) gives:
  - state IDLE, `idx`=0, `checksum`=0.
  - `out_valid`=0, `busy`=0, `dump_done`=0, `out_idx`=0.
  - `out_data`=`rf_rdat1`; `rf_*` outputs in pass-through.
- A reset in the middle of a dump aborts it without a `dump_done` pulse.
- `busy`, `out_valid` and `dump_done` are decoded from registered state, with no combinational path from `dump_start`.
- `out_data` depends combinationally on `rf_rdat1`, and is stable because writes are blocked.
- With `dump_start` seen at edge k and `out_ready` held at 1:
  - DRAIN is the cycle after k.
  - The first word is valid after edge k+1.
  - The last word is accepted at edge k+1+W, where W = NREGS - SKIP_ZERO.
  - `dump_done` is high in the cycle after that edge, and `busy` drops one cycle later.
- A dump takes W+2 cycles plus any backpressure stall cycles.
- `checksum` is final when `dump_done`=1.

## Structure
- Shared package `reg_dump_pkg` holds:
  - `dump_state_t` enum {IDLE, DRAIN, READ, DONE}.
  - the `regbits_t`/word typedefs used with the register file interface.
- No sub-module: a single FSM plus an index counter and an accumulator. The bench instantiates the existing register file as the target.

## Test plan
- Reset, then write register r5 = 0xDEADBEEF through pass-through, then pulse `dump_start` with `out_ready`=1. Required:
  - 31 words, indices 1..31, `out_data`=0xDEADBEEF at `out_idx`=5 and 0 elsewhere.
  - `dump_done` after exactly 33 cycles.
  - `checksum`=0xDEADBEEF.
- Load r1..r31 with the value i, SKIP_ZERO=1. Required: `checksum`=496 (0x1F0), and `out_idx` strictly increments.
- Backpressure: toggle `out_ready` 1,0,0,1,... Required: no word duplicated or skipped, and `out_data`/`out_idx` stable while valid and not ready.
- Hold `dp_WEN`=1 targeting r3 with 0x1234 throughout the dump. Required: `rf_WEN`=0 in every busy cycle, and r3 is unchanged after the dump.
- Write r7=0xA5A5A5A5 in the same cycle `dump_start` is first seen. Required: the dump reports 0xA5A5A5A5 at index 7 (write lands during DRAIN).
- Assert `n_rst` low while at `out_idx`=10, then release. Required:
  - `busy`=0, `out_valid`=0, no `dump_done`, `checksum`=0.
  - A following `dump_start` produces a complete dump.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared types for the register-dump sequencer and its register file interface.
package reg_dump_pkg;

   // Dump sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } dump_state_t;

   // Default register-file geometry: 32 registers of 32 bits
   typedef logic [4:0]  regbits_t;
   typedef logic [31:0] word_t;

endpackage

// File: rtl/reg_dump_ctrl.sv
// Register dump sequencer: transparent between datapath and register file when
// idle; on request it takes read port 1, blocks writes, and streams every
// register over a valid/ready handshake while accumulating a checksum.
module reg_dump_ctrl
   import reg_dump_pkg::*;
#(
   parameter int NREGS     = 32,
   parameter int AW        = 5,
   parameter int DW        = 32,
   parameter int SKIP_ZERO = 1
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          dump_start,
   input  logic          dp_WEN,
   input  logic [AW-1:0] dp_wsel,
   input  logic [DW-1:0] dp_wdat,
   input  logic [AW-1:0] dp_rsel1,
   input  logic [AW-1:0] dp_rsel2,
   output logic          rf_WEN,
   output logic [AW-1:0] rf_wsel,
   output logic [DW-1:0] rf_wdat,
   output logic [AW-1:0] rf_rsel1,
   output logic [AW-1:0] rf_rsel2,
   input  logic [DW-1:0] rf_rdat1,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [AW-1:0] out_idx,
   output logic          busy,
   output logic          dump_done,
   output logic [DW-1:0] checksum
);

   localparam logic [AW-1:0] FIRST_IDX = (SKIP_ZERO != 0) ? AW'(1) : '0;
   localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

   dump_state_t   state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [DW-1:0] checksum_q, checksum_d;

   // Next-state, index and checksum update
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      checksum_d = checksum_q;
      case (state_q)
         IDLE: begin
            if (dump_start) begin
               state_d    = DRAIN;
               idx_d      = FIRST_IDX;
               checksum_d = '0;
            end
         end
         // One dead cycle so a write from the last pass-through cycle has landed
         DRAIN: state_d = READ;
         READ: begin
            if (out_ready) begin
               checksum_d = checksum_q + rf_rdat1;
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset aborts any dump in progress
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         checksum_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         checksum_q <= checksum_d;
      end
   end

   // Output decode from registered state; write path and port 2 pass through
   always_comb begin
      busy      = (state_q != IDLE);
      out_valid = (state_q == READ);
      dump_done = (state_q == DONE);
      rf_WEN    = busy ? 1'b0 : dp_WEN;
      rf_wsel   = dp_wsel;
      rf_wdat   = dp_wdat;
      rf_rsel2  = dp_rsel2;
      rf_rsel1  = out_valid ? idx_q : dp_rsel1;
      out_idx   = out_valid ? idx_q : '0;
      out_data  = rf_rdat1;
      checksum  = checksum_q;
   end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Bench for reg_dump_ctrl with a behavioural register file (falling-edge
// write, combinational read) and a scoreboard of expected dump words.
module tb_reg_dump_ctrl;
   import reg_dump_pkg::*;

   localparam int NREGS     = 32;
   localparam int AW        = 5;
   localparam int DW        = 32;
   localparam int SKIP_ZERO = 1;
   localparam int W         = NREGS - SKIP_ZERO;

   logic          clk;
   logic          n_rst;
   logic          dump_start;
   logic          dp_WEN;
   logic [AW-1:0] dp_wsel;
   logic [DW-1:0] dp_wdat;
   logic [AW-1:0] dp_rsel1;
   logic [AW-1:0] dp_rsel2;
   logic          rf_WEN;
   logic [AW-1:0] rf_wsel;
   logic [DW-1:0] rf_wdat;
   logic [AW-1:0] rf_rsel1;
   logic [AW-1:0] rf_rsel2;
   logic [DW-1:0] rf_rdat1;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_idx;
   logic          busy;
   logic          dump_done;
   logic [DW-1:0] checksum;

   typedef struct packed {
      regbits_t idx;
      word_t    data;
   } sb_t;

   sb_t   sb[$];
   word_t exp_regs [NREGS];
   word_t rf_mem   [NREGS];
   logic  rf_clr;
   int    checks = 0;
   int    errors = 0;
   int    done_n = 0;
   logic          prev_stall;
   logic [AW-1:0] prev_idx;
   logic [DW-1:0] prev_data;

   reg_dump_ctrl #(.NREGS(NREGS), .AW(AW), .DW(DW), .SKIP_ZERO(SKIP_ZERO)) dut (
      .clk(clk), .n_rst(n_rst), .dump_start(dump_start),
      .dp_WEN(dp_WEN), .dp_wsel(dp_wsel), .dp_wdat(dp_wdat),
      .dp_rsel1(dp_rsel1), .dp_rsel2(dp_rsel2),
      .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
      .rf_rsel1(rf_rsel1), .rf_rsel2(rf_rsel2), .rf_rdat1(rf_rdat1),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .busy(busy), .dump_done(dump_done), .checksum(checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: r0 reads zero, writes land on the falling edge
   always @(negedge clk) begin
      if (rf_clr) begin
         for (int i = 0; i < NREGS; i++) rf_mem[i] <= '0;
      end else if (rf_WEN && rf_wsel != '0) begin
         rf_mem[rf_wsel] <= rf_wdat;
      end
   end
   assign rf_rdat1 = rf_mem[rf_rsel1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Stream monitor: pops the scoreboard on every accepted word
   always @(negedge clk) begin
      if (n_rst && busy) chk("wen_blocked", 32'(rf_WEN), 32'd0);
      if (n_rst && dump_done) done_n++;
      if (n_rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_underflow observed idx=%0d expected no word", out_idx);
         end else begin
            sb_t e;
            e = sb.pop_front();
            chk("word_idx", 32'(out_idx), 32'(e.idx));
            chk("word_data", out_data, e.data);
         end
      end
      if (n_rst && prev_stall && out_valid) begin
         chk("hold_idx", 32'(out_idx), 32'(prev_idx));
         chk("hold_data", out_data, prev_data);
      end
      prev_stall <= n_rst && out_valid && !out_ready;
      prev_idx   <= out_idx;
      prev_data  <= out_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input regbits_t a, input word_t d);
      dp_WEN  = 1'b1;
      dp_wsel = a;
      dp_wdat = d;
      exp_regs[a] = d;
      tick();
      dp_WEN = 1'b0;
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0,1
   task automatic run_dump(input int mode, input bit hold_wen, input bit start_wr,
                           input regbits_t wa, input word_t wd, input bit abort,
                           output word_t exp_sum);
      int c;
      int busy_cnt;
      int stalls;
      int done_c;
      int done0;
      bit aborted;
      if (start_wr) begin
         exp_regs[wa] = wd;
         dp_WEN  = 1'b1;
         dp_wsel = wa;
         dp_wdat = wd;
      end
      exp_sum = '0;
      for (int i = SKIP_ZERO; i < NREGS; i++) begin
         sb.push_back('{idx: regbits_t'(i), data: exp_regs[i]});
         exp_sum += exp_regs[i];
      end
      dump_start = 1'b1;
      out_ready  = 1'b1;
      tick();
      dump_start = 1'b0;
      dp_WEN     = 1'b0;
      if (hold_wen) begin
         dp_WEN  = 1'b1;
         dp_wsel = 5'd3;
         dp_wdat = 32'h0000_1234;
      end
      chk("drain_busy", 32'(busy), 32'd1);
      chk("drain_valid", 32'(out_valid), 32'd0);
      c = 0; busy_cnt = 1; stalls = 0; done_c = -1; done0 = done_n; aborted = 1'b0;
      while (busy && c < 200 && !aborted) begin
         out_ready = (mode == 1) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
         if (out_valid && !out_ready) stalls++;
         tick();
         c++;
         if (!busy) dp_WEN = 1'b0;
         if (busy) busy_cnt++;
         if (dump_done) done_c = c;
         if (abort && out_valid && out_idx == 5'd10) begin
            n_rst = 1'b0;
            #1;
            sb.delete();
            aborted = 1'b1;
         end
      end
      dp_WEN    = 1'b0;
      out_ready = 1'b1;
      if (aborted) return;
      if (c >= 200) chk("dump_timeout", 32'(c), 32'd0);
      chk("done_cycle", 32'(done_c), 32'(W + 1 + stalls));
      chk("busy_cycles", 32'(busy_cnt), 32'(W + 2 + stalls));
      #5;
      chk("done_pulses", 32'(done_n - done0), 32'd1);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("checksum", checksum, exp_sum);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      word_t s;
      int    d0;
      n_rst = 1'b0; dump_start = 1'b0; dp_WEN = 1'b0; dp_wsel = '0; dp_wdat = '0;
      dp_rsel1 = 5'd2; dp_rsel2 = 5'd4; out_ready = 1'b1; rf_clr = 1'b1;
      for (int i = 0; i < NREGS; i++) exp_regs[i] = '0;
      tick(); tick();
      rf_clr = 1'b0;
      // Reset state and pass-through
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_done", 32'(dump_done), 32'd0);
      chk("rst_idx", 32'(out_idx), 32'd0);
      chk("rst_checksum", checksum, 32'd0);
      n_rst = 1'b1;
      tick();
      dp_WEN = 1'b1; dp_wsel = 5'd9; dp_wdat = 32'h0BAD_F00D; dp_rsel1 = 5'd6; dp_rsel2 = 5'd8;
      #1;
      chk("pt_wen", 32'(rf_WEN), 32'd1);
      chk("pt_wsel", 32'(rf_wsel), 32'd9);
      chk("pt_wdat", rf_wdat, 32'h0BAD_F00D);
      chk("pt_rsel1", 32'(rf_rsel1), 32'd6);
      chk("pt_rsel2", 32'(rf_rsel2), 32'd8);
      chk("pt_rdat", out_data, rf_mem[6]);
      dp_WEN = 1'b0;
      tick();

      // Single nonzero register
      write_reg(5'd5, 32'hDEAD_BEEF);
      write_reg(5'd9, 32'h0);
      run_dump(0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, s);
      chk("sum_deadbeef", checksum, 32'hDEAD_BEEF);
      tick();

      // r_i = i
      for (int i = 1; i < NREGS; i++) write_reg(regbits_t'(i), word_t'(i));
      run_dump(0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, s);
      chk("sum_496", checksum, 32'h0000_01F0);
      tick();

      // Backpressure
      run_dump(1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, s);
      chk("sum_bp", checksum, 32'h0000_01F0);
      tick();

      // Writes held during the dump are dropped
      run_dump(0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, s);
      tick();
      chk("r3_unchanged", rf_mem[3], 32'd3);

      // Write in the dump_start cycle lands before the read
      run_dump(0, 1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, s);
      chk("sum_r7", checksum, 32'h0000_01F0 - 32'd7 + 32'hA5A5_A5A5);
      tick();

      // Reset in mid-dump
      d0 = done_n;
      run_dump(0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, s);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_checksum", checksum, 32'd0);
      tick(); tick();
      n_rst = 1'b1;
      tick();
      chk("abort_busy2", 32'(busy), 32'd0);
      chk("abort_done", 32'(dump_done), 32'd0);
      chk("abort_no_pulse", 32'(done_n - d0), 32'd0);
      chk("abort_checksum2", checksum, 32'd0);
      run_dump(0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, s);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
